shift_deserializer: RTL and testbench
=====================================

# shift_deserializer

Serial-to-parallel receiver for the shift-register datapath: it collects a bit stream, one bit per accepted strobe, into an n-bit word. Bit order is selectable to match the sending shifter's `direction`. Each completed word is presented on a one-entry holding register with a valid/ready handshake. The block is the receiving end of the serial link driven by the team's bidirectional shift registers.

## Interface
- `n`, 16, data word width; legal range 2..64.
- `clk`  input  1  rising-edge clock; single clock domain.
- `reset`  input  1  asynchronous, active-low reset; clears all state immediately.
- `si`  input  1  serial data bit.
- `si_valid`  input  1  `si` is valid this cycle.
- `si_ready`  output  1  block accepts `si` this cycle; a bit is transferred when `si_valid && si_ready`.
- `direction`  input  1  bit order. 1: first bit lands at the MSB (left shift, enter at LSB). 0: first bit lands at the LSB (right shift, enter at MSB).
- `sync`  input  1  synchronous abort of the partial word.
- `out`  output  n  received word (holding register).
- `out_valid`  output  1  `out` holds an unconsumed word.
- `out_ready`  input  1  consumer takes `out`; the transfer occurs when `out_valid && out_ready`.
- `out_perr`  output  1  parity error flag for the word on `out`.

## Operation
- Internal state: shift register `sr[n-1:0]`, bit counter `cnt` (clog2(n+1) bits), latched direction `dir_q`, and holding register `out`/`out_valid`/`out_perr`.
- FSM states:
  - RECV: collecting data bits.
  - PAR: collecting the parity bit; exists only with `PARITY_EN`.
- Per accepted bit in RECV:
  - `dir_q`=1: `sr <= {sr[n-2:0], si}`.
  - `dir_q`=0: `sr <= {si, sr[n-1:1]}`.
  - `cnt` increments.
- `dir_q` is captured from `direction` on the first bit of each word (`cnt`==0). Changes to `direction` mid-word are ignored until the next word.
- Word completion without `PARITY_EN`: on the n-th accepted bit, load the assembled word (including that bit) into `out`, set `out_valid`=1, clear `cnt`, stay in RECV.
- Word completion with `PARITY_EN`: the n-th data bit moves the FSM to PAR. The next accepted bit is parity. The word is then loaded, with `out_perr` = XOR of all n data bits and the parity bit (even parity; 1 = error). The FSM returns to RECV.
- Backpressure:
  - `si_ready` = 0 only when the next accepted bit would complete a frame while `out_valid`=1.
  - `si_ready` does not depend on `out_ready`, so there is no combinational path from `out_ready`.
  - No word is ever dropped or overwritten.
- Output handshake: when `out_valid && out_ready`, clear `out_valid`. If a frame completes in the same cycle, the load wins and `out_valid` stays 1 with the new word. This case is reachable only when `out_valid` was 0 at the start of the cycle, since `si_ready` blocks it otherwise.
- `sync`=1: `cnt` <= 0 and the FSM goes to RECV; a bit presented in the same cycle is discarded. The holding register is unaffected.
- `sr` contents between words are don't-care; only `out` is architecturally visible.

## Timing
- Reset values: `out`=0, `out_valid`=0, `out_perr`=0, `si_ready`=1, `cnt`=0, FSM=RECV, `dir_q`=0.
- Latency: `out_valid` rises on the clock edge that accepts the final frame bit and is visible the following cycle.
- Throughput: one bit per cycle sustained, as long as the consumer drains `out` before the next frame completes.
- Stall: while `si_ready`=0, `si_valid` is ignored and no state changes except through the output handshake. `si_ready` returns to 1 the cycle after `out` is consumed.
- Reset asserted mid-word or mid-handshake: all outputs return to their reset values asynchronously; the partial word is lost.

## Configuration
- Macro: `SHIFT_DESER_PARITY_EN`.
- Defined: frame is n+1 bits and the PAR state exists. `out_perr` reports even-parity failure and is held with the word until it is consumed.
- Undefined: frame is n bits and the PAR state is absent. `out_perr` is tied to 0; the port stays present so the interface is stable.

## Structure
- Shared package `shift_pkg`:
  - FSM state enum (RECV, PAR).
  - Direction constants `DIR_LEFT`=1 and `DIR_RIGHT`=0.
  - Width helper for `cnt`.
- One sub-module, `shift_deser_hold`: one-entry valid/ready holding register carrying `out`, `out_valid` and `out_perr`. It also produces the "holding full" signal used for the `si_ready` stall term.

## Test plan
All scenarios use `n`=8.
- Bit order left: `direction`=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, `out_ready`=1 → `out`=8'hB2 with `out_valid` for one cycle, one cycle after the last bit.
- Bit order right: `direction`=0, same bits → `out`=8'h4D. Toggling `direction` after the first bit → still 8'h4D.
- Backpressure: `out_ready`=0, stream 16 bits 8'hA5 then 8'h3C → `out`=8'hA5 is held and `si_ready`=0 at the 16th bit. Pulse `out_ready` → 8'hA5 consumed, 16th bit accepted next cycle, `out`=8'h3C.
- Sync abort: 3 bits, then `sync`=1 with `si_valid`=1, then 8 bits 8'hFF → single word 8'hFF; the aborted bits and the sync-cycle bit do not appear.
- Reset mid-word: 5 bits, then `reset` low for one cycle → `out`=0, `out_valid`=0, `si_ready`=1; the next 8 bits form a clean word.
- Parity (`SHIFT_DESER_PARITY_EN` defined): 8'hB2 plus parity bit 0 → `out_perr`=0. Same word plus parity bit 1 → `out_perr`=1.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
// Module : shift_pkg
// Shared types, constants and helpers for the shift-register serial datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef enum logic [0:0] {
        RECV = 1'b0,
        PAR  = 1'b1
    } deser_state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // Counter must hold values 0..w so a parity frame can park at w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_deser_hold.sv
// ============================================================================
// Module : shift_deser_hold
// One-entry valid/ready holding register for completed deserializer words.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_deser_hold #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [n-1:0] i_data,
    input  logic         i_perr,
    input  logic         i_ready,
    output logic [n-1:0] o_data,
    output logic         o_valid,
    output logic         o_perr,
    output logic         o_full
);

    logic [n-1:0] r_data;
    logic         r_valid;
    logic         r_perr;

    // A load in the same cycle as a consume wins, so the new word is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_perr  <= i_perr;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_perr  = r_perr;
    assign o_full  = r_valid;

endmodule

`default_nettype wire

// File: rtl/shift_deserializer.sv
// ============================================================================
// Module : shift_deserializer
// Serial-to-parallel receiver with selectable bit order and output handshake.
// Optional even-parity frame bit enabled by macro SHIFT_DESER_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_deserializer
    import shift_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         si,
    input  logic         si_valid,
    output logic         si_ready,
    input  logic         direction,
    input  logic         sync,
    output logic [n-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_perr
);

    localparam int            CW     = cnt_width(n);
    localparam logic [CW-1:0] C_LAST = CW'(n - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    deser_state_t  r_state, w_state_nxt;
    logic [n-1:0]  r_sr, w_sr_nxt, w_shifted, w_load_word;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_dir, w_dir_nxt, w_dir_eff;
    logic          w_accept, w_frame_end, w_load, w_load_perr, w_full;

    // The first bit of a word uses the live direction; later bits the latched one.
    assign w_dir_eff = (r_cnt == '0) ? direction : r_dir;
    assign w_shifted = (w_dir_eff == DIR_LEFT) ? {r_sr[n-2:0], si} : {si, r_sr[n-1:1]};

`ifdef SHIFT_DESER_PARITY_EN
    assign w_frame_end = (r_state == PAR);
`else
    assign w_frame_end = (r_cnt == C_LAST);
`endif

    assign si_ready = !(w_frame_end && w_full);
    assign w_accept = si_valid && si_ready && !sync;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_dir_nxt   = r_dir;
        w_load      = 1'b0;
        w_load_word = w_shifted;
        w_load_perr = 1'b0;
        if (sync) begin
            w_cnt_nxt   = '0;
            w_state_nxt = RECV;
        end else if (w_accept) begin
            case (r_state)
                RECV: begin
                    w_sr_nxt = w_shifted;
                    if (r_cnt == '0) begin
                        w_dir_nxt = direction;
                    end
`ifdef SHIFT_DESER_PARITY_EN
                    w_cnt_nxt = r_cnt + C_ONE;
                    if (r_cnt == C_LAST) begin
                        w_state_nxt = PAR;
                    end
`else
                    if (r_cnt == C_LAST) begin
                        w_load    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + C_ONE;
                    end
`endif
                end
`ifdef SHIFT_DESER_PARITY_EN
                PAR: begin
                    w_load      = 1'b1;
                    w_load_word = r_sr;
                    w_load_perr = ^{r_sr, si};
                    w_cnt_nxt   = '0;
                    w_state_nxt = RECV;
                end
`endif
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RECV;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RECV;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_dir   <= DIR_RIGHT;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sr    <= w_sr_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    shift_deser_hold #(
        .n (n)
    ) u_hold (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_load),
        .i_data  (w_load_word),
        .i_perr  (w_load_perr),
        .i_ready (out_ready),
        .o_data  (out),
        .o_valid (out_valid),
        .o_perr  (out_perr),
        .o_full  (w_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_shift_deserializer.sv
// ============================================================================
// Module : tb_shift_deserializer
// Scoreboard bench for shift_deserializer with n = 8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_deserializer;

    localparam int N = 8;
`ifdef SHIFT_DESER_PARITY_EN
    localparam int FLEN = N + 1;
`else
    localparam int FLEN = N;
`endif

    typedef struct {
        logic [N-1:0] word;
        logic         perr;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         si = 1'b0;
    logic         si_valid = 1'b0;
    logic         si_ready;
    logic         direction = 1'b1;
    logic         sync = 1'b0;
    logic [N-1:0] out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_perr;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    shift_deserializer #(.n(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .si        (si),
        .si_valid  (si_valid),
        .si_ready  (si_ready),
        .direction (direction),
        .sync      (sync),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_perr  (out_perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", {56'd0, out}, 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_word", {56'd0, out}, {56'd0, e.word});
                chk("sb_perr", {63'd0, out_perr}, {63'd0, e.perr});
            end
        end
    end

    function automatic logic frame_bit(input logic [N-1:0] w, input logic order,
                                       input logic pbit, input int i);
        if (i == N) return pbit;
        return (order == 1'b1) ? w[N-1-i] : w[i];
    endfunction

    task automatic send_bit(input logic b);
        int k;
        k = 0;
        si       = b;
        si_valid = 1'b1;
        @(negedge clk);
        while (!si_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!si_ready) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        si_valid = 1'b0;
    endtask

    // Sends the first 'upto' bits of a frame and records its expected result.
    task automatic send_frame(input logic [N-1:0] w, input logic order, input logic toggle,
                              input logic pbit, input int upto);
        exp_t e;
        e.word = w;
`ifdef SHIFT_DESER_PARITY_EN
        e.perr = (^w) ^ pbit;
`else
        e.perr = 1'b0;
`endif
        exp_q.push_back(e);
        direction = order;
        for (int i = 0; i < upto; i++) begin
            send_bit(frame_bit(w, order, pbit, i));
            if (i == 0 && toggle) direction = ~order;
        end
        direction = order;
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] w;
        logic         lastb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {56'd0, out}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_perr", {63'd0, out_perr}, 64'd0);
        chk("rst_ready", {63'd0, si_ready}, 64'd1);
        reset = 1'b1;
        out_ready = 1'b1;
        idle(1);

        // Left order: bits 1,0,1,1,0,0,1,0 -> 8'hB2, valid one cycle after last bit
        send_frame(8'hB2, 1'b1, 1'b0, ^8'hB2, FLEN);
        chk("left_valid", {63'd0, out_valid}, 64'd1);
        chk("left_out", {56'd0, out}, 64'hB2);
        idle(1);
        chk("left_valid_drop", {63'd0, out_valid}, 64'd0);

        // Right order, same bits -> 8'h4D; then with direction toggled mid-word
        send_frame(8'h4D, 1'b0, 1'b0, ^8'h4D, FLEN);
        chk("right_out", {56'd0, out}, 64'h4D);
        send_frame(8'h4D, 1'b0, 1'b1, ^8'h4D, FLEN);
        chk("toggle_out", {56'd0, out}, 64'h4D);
        idle(2);

        // Backpressure: A5 held, final bit of 3C stalls until A5 is consumed
        out_ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, ^8'hA5, FLEN);
        send_frame(8'h3C, 1'b1, 1'b0, ^8'h3C, FLEN - 1);
        w     = 8'h3C;
        lastb = frame_bit(w, 1'b1, ^w, FLEN - 1);
        si       = lastb;
        si_valid = 1'b1;
        idle(3);
        chk("bp_ready_low", {63'd0, si_ready}, 64'd0);
        chk("bp_hold_out", {56'd0, out}, 64'hA5);
        chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        idle(1);
        chk("bp_ready_back", {63'd0, si_ready}, 64'd1);
        idle(1);
        si_valid = 1'b0;
        chk("bp_second_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_second_out", {56'd0, out}, 64'h3C);
        idle(2);

        // Sync abort: partial bits and the sync-cycle bit are discarded
        direction = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        si = 1'b0;
        si_valid = 1'b1;
        sync = 1'b1;
        idle(1);
        sync = 1'b0;
        si_valid = 1'b0;
        send_frame(8'hFF, 1'b1, 1'b0, ^8'hFF, FLEN);
        chk("sync_out", {56'd0, out}, 64'hFF);
        idle(2);

        // Reset mid-word
        direction = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        reset = 1'b0;
        #1;
        chk("mid_rst_out", {56'd0, out}, 64'd0);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, si_ready}, 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, ^8'h5A, FLEN);
        chk("post_rst_out", {56'd0, out}, 64'h5A);
        idle(2);

`ifdef SHIFT_DESER_PARITY_EN
        // Parity: good then bad parity bit on the same word
        send_frame(8'hB2, 1'b1, 1'b0, 1'b0, FLEN);
        chk("par_good", {63'd0, out_perr}, 64'd0);
        send_frame(8'hB2, 1'b1, 1'b0, 1'b1, FLEN);
        chk("par_bad", {63'd0, out_perr}, 64'd1);
        idle(2);
`endif

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
